clock_set_ctrl: RTL and testbench



---
 rtl/clock_set_ctrl_pkg.sv | 29 ++
 rtl/clock_set_ctrl_btn_repeat.sv | 67 ++++++
 rtl/clock_set_ctrl.sv | 132 +++++++++++++
 tb/tb_clock_set_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_set_ctrl_pkg.sv
// Shared types and constants for the clock mode/set sequencer.
package clock_ctrl_pkg;

   typedef enum logic [2:0] {
      RUN        = 3'd0,
      SET_HR     = 3'd1,
      SET_MIN    = 3'd2,
      SET_AL_HR  = 3'd3,
      SET_AL_MIN = 3'd4
   } mode_t;

   localparam logic [1:0] BLINK_NONE = 2'd0;
   localparam logic [1:0] BLINK_HR   = 2'd1;
   localparam logic [1:0] BLINK_MIN  = 2'd2;

   // Mode button walks the set fields in a fixed ring back to RUN.
   function automatic mode_t next_mode(input mode_t m);
      mode_t n;
      case (m)
         RUN:        n = SET_HR;
         SET_HR:     n = SET_MIN;
         SET_MIN:    n = SET_AL_HR;
         SET_AL_HR:  n = SET_AL_MIN;
         default:    n = RUN;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_repeat.sv
// Edge detector plus long-press auto-repeat for the increment button.
// press_evt is combinational and single-cycle; the top registers it.
module btn_repeat #(
   parameter int HOLD_CYCLES   = 1000,
   parameter int REPEAT_CYCLES = 200
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   input  logic clear,
   input  logic rpt_en,
   output logic press_evt
);

   localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             btn_prev;
   logic             armed;
   logic             repeating;
   logic [CNT_W-1:0] cnt;
   logic             rise;
   logic             hold_hit;
   logic             rep_hit;

   // A held press only repeats if it was accepted as a fresh rise and never cancelled.
   always_comb begin
      rise      = btn & ~btn_prev;
      hold_hit  = armed & btn & rpt_en & ~repeating & (cnt == HOLD_LIM);
      rep_hit   = armed & btn & rpt_en &  repeating & (cnt == REP_LIM);
      press_evt = ~clear & (rise | hold_hit | rep_hit);
   end

   // Previous level resets high so a button held through reset gives no edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_prev  <= 1'b1;
         armed     <= 1'b0;
         repeating <= 1'b0;
         cnt       <= '0;
      end else begin
         btn_prev <= btn;
         if (clear || !btn) begin
            armed     <= 1'b0;
            repeating <= 1'b0;
            cnt       <= '0;
         end else if (rise) begin
            armed     <= 1'b1;
            repeating <= 1'b0;
            cnt       <= CNT_ONE;
         end else if (armed && rpt_en) begin
            if (hold_hit) begin
               repeating <= 1'b1;
               cnt       <= CNT_ONE;
            end else if (rep_hit) begin
               cnt <= CNT_ONE;
            end else begin
               cnt <= cnt + CNT_ONE;
            end
         end
      end
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/set sequencer: FSM over the set fields, inactivity timeout and
// registered decode of hold, blink and increment strobes.
module clock_set_ctrl
   import clock_ctrl_pkg::*;
#(
   parameter int HOLD_CYCLES    = 1000,
   parameter int REPEAT_CYCLES  = 200,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mode_btn,
   input  logic       inc_btn,
   output mode_t      mode,
   output logic       time_hold,
   output logic [1:0] blink_sel,
   output logic       inc_hr,
   output logic       inc_min,
   output logic       inc_al_hr,
   output logic       inc_al_min,
   output logic       alarm_en
);

   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);

   mode_t             state_q;
   mode_t             next_state;
   logic              mode_prev;
   logic              mode_rise;
   logic              in_set;
   logic              inc_evt;
   logic [IDLE_W-1:0] idle_cnt;

   logic       nxt_hold;
   logic [1:0] nxt_blink;
   logic       nxt_inc_hr;
   logic       nxt_inc_min;
   logic       nxt_inc_al_hr;
   logic       nxt_inc_al_min;
   logic       nxt_alarm;

   assign mode_rise = mode_btn & ~mode_prev;
   assign in_set    = (state_q != RUN);
   assign mode      = state_q;

   // A mode rise cancels any same-cycle increment and disarms a held press.
   btn_repeat #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_inc_repeat (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn       (inc_btn),
      .clear     (mode_rise),
      .rpt_en    (in_set),
      .press_evt (inc_evt)
   );

   // Next state and next-cycle output values; mode rise outranks the timeout.
   always_comb begin
      next_state     = state_q;
      nxt_hold       = 1'b0;
      nxt_blink      = BLINK_NONE;
      nxt_inc_hr     = 1'b0;
      nxt_inc_min    = 1'b0;
      nxt_inc_al_hr  = 1'b0;
      nxt_inc_al_min = 1'b0;
      nxt_alarm      = alarm_en;

      if (mode_rise) begin
         next_state = next_mode(state_q);
      end else if (in_set && !mode_btn && !inc_btn && (idle_cnt == IDLE_LIM)) begin
         next_state = RUN;
      end

      case (state_q)
         RUN:        nxt_alarm      = alarm_en ^ inc_evt;
         SET_HR:     nxt_inc_hr     = inc_evt;
         SET_MIN:    nxt_inc_min    = inc_evt;
         SET_AL_HR:  nxt_inc_al_hr  = inc_evt;
         SET_AL_MIN: nxt_inc_al_min = inc_evt;
         default:    nxt_alarm      = alarm_en;
      endcase

      case (next_state)
         SET_HR:     begin nxt_hold = 1'b1; nxt_blink = BLINK_HR;  end
         SET_MIN:    begin nxt_hold = 1'b1; nxt_blink = BLINK_MIN; end
         SET_AL_HR:  nxt_blink = BLINK_HR;
         SET_AL_MIN: nxt_blink = BLINK_MIN;
         default:    nxt_blink = BLINK_NONE;
      endcase
   end

   // State and every output are registered so effects land one cycle after the sampled edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         mode_prev  <= 1'b1;
         time_hold  <= 1'b0;
         blink_sel  <= BLINK_NONE;
         inc_hr     <= 1'b0;
         inc_min    <= 1'b0;
         inc_al_hr  <= 1'b0;
         inc_al_min <= 1'b0;
         alarm_en   <= 1'b0;
      end else begin
         state_q    <= next_state;
         mode_prev  <= mode_btn;
         time_hold  <= nxt_hold;
         blink_sel  <= nxt_blink;
         inc_hr     <= nxt_inc_hr;
         inc_min    <= nxt_inc_min;
         inc_al_hr  <= nxt_inc_al_hr;
         inc_al_min <= nxt_inc_al_min;
         alarm_en   <= nxt_alarm;
      end
   end

   // Idle counter runs only in set states with both buttons released; saturates at the trip point.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt <= '0;
      end else if (!in_set || (next_state != state_q) || mode_btn || inc_btn) begin
         idle_cnt <= '0;
      end else if (idle_cnt != IDLE_LIM) begin
         idle_cnt <= idle_cnt + IDLE_ONE;
      end
   end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl with short hold/repeat/timeout values.
module tb_clock_set_ctrl;

   localparam int HOLD = 8;
   localparam int REP  = 3;
   localparam int TMO  = 20;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       mode_btn = 1'b0;
   logic       inc_btn  = 1'b1;
   logic [2:0] mode;
   logic       time_hold;
   logic [1:0] blink_sel;
   logic       inc_hr;
   logic       inc_min;
   logic       inc_al_hr;
   logic       inc_al_min;
   logic       alarm_en;

   int cyc        = 0;
   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      int         cyc;
      logic [10:0] snap;
   } exp_t;

   exp_t        expQ[$];
   logic [10:0] prevSnap = '0;

   clock_set_ctrl #(
      .HOLD_CYCLES    (HOLD),
      .REPEAT_CYCLES  (REP),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode_btn   (mode_btn),
      .inc_btn    (inc_btn),
      .mode       (mode),
      .time_hold  (time_hold),
      .blink_sel  (blink_sel),
      .inc_hr     (inc_hr),
      .inc_min    (inc_min),
      .inc_al_hr  (inc_al_hr),
      .inc_al_min (inc_al_min),
      .alarm_en   (alarm_en)
   );

   // Free-running clock and posedge index used to timestamp expected events.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Snapshot layout: {mode[2:0], time_hold, blink_sel[1:0], hr, min, al_hr, al_min, alarm_en}.
   function automatic logic [10:0] curSnap();
      return {mode, time_hold, blink_sel, inc_hr, inc_min, inc_al_hr, inc_al_min, alarm_en};
   endfunction

   function automatic logic [10:0] mkSnap(input logic [2:0] m, input logic [3:0] stb, input logic al);
      logic       th;
      logic [1:0] bs;
      case (m)
         3'd1:    begin th = 1'b1; bs = 2'd1; end
         3'd2:    begin th = 1'b1; bs = 2'd2; end
         3'd3:    begin th = 1'b0; bs = 2'd1; end
         3'd4:    begin th = 1'b0; bs = 2'd2; end
         default: begin th = 1'b0; bs = 2'd0; end
      endcase
      return {m, th, bs, stb, al};
   endfunction

   task automatic pushExp(input int c, input logic [2:0] m, input logic [3:0] stb, input logic al);
      exp_t e;
      e.cyc  = c;
      e.snap = mkSnap(m, stb, al);
      expQ.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic applyStimulus(input logic m, input logic i);
      mode_btn = m;
      inc_btn  = i;
   endtask

   task automatic checkOutput(input string name, input logic [10:0] act, input logic [10:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic pressMode(input logic [2:0] newMode, input logic al);
      int k;
      k = cyc + 1;
      applyStimulus(1'b1, 1'b0);
      pushExp(k, newMode, 4'b0000, al);
      step(1);
      applyStimulus(1'b0, 1'b0);
      step(1);
   endtask

   // Monitor: any strobe or change in mode/hold/blink/alarm is an output event to score.
   always @(negedge clk) begin
      logic [10:0] s;
      exp_t        e;
      s = curSnap();
      if (!rst_n) begin
         prevSnap = s;
      end else begin
         if ((s[4:1] != 4'b0000) || (s[10:5] != prevSnap[10:5]) || (s[0] != prevSnap[0])) begin
            compared++;
            if (expQ.size() == 0) begin
               mismatched++;
               $display("[TB] FAIL unexpected_output at cycle %0d: got %h, expected none", cyc, s);
            end else begin
               e = expQ.pop_front();
               if ((e.cyc != cyc) || (e.snap !== s)) begin
                  mismatched++;
                  $display("[TB] FAIL scoreboard: got %h at cycle %0d, expected %h at cycle %0d",
                           s, cyc, e.snap, e.cyc);
               end
            end
         end
         prevSnap = s;
      end
   end

   // Hard time limit so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus; expected events are queued before they can appear.
   initial begin
      int k;

      // Reset with inc held; no edge after release.
      step(3);
      checkOutput("reset_state", curSnap(), 11'h000);
      rst_n = 1'b1;
      step(3);
      checkOutput("no_edge_after_reset", curSnap(), 11'h000);

      // Re-press inc in RUN toggles alarm.
      applyStimulus(1'b0, 1'b0);
      step(1);
      k = cyc + 1;
      applyStimulus(1'b0, 1'b1);
      pushExp(k, 3'd0, 4'b0000, 1'b1);
      step(1);
      applyStimulus(1'b0, 1'b0);
      step(2);

      // Walk the full mode ring.
      pressMode(3'd1, 1'b1);
      pressMode(3'd2, 1'b1);
      pressMode(3'd3, 1'b1);
      pressMode(3'd4, 1'b1);
      pressMode(3'd0, 1'b1);

      // Simultaneous mode and inc rise in SET_HR: mode wins, held inc stays silent.
      pressMode(3'd1, 1'b1);
      k = cyc + 1;
      applyStimulus(1'b1, 1'b1);
      pushExp(k, 3'd2, 4'b0000, 1'b1);
      step(1);
      applyStimulus(1'b0, 1'b1);
      step(12);
      applyStimulus(1'b0, 1'b0);
      step(2);

      // Long press in SET_MIN: strobes at k, k+8, k+11, k+14, k+17.
      k = cyc + 1;
      applyStimulus(1'b0, 1'b1);
      pushExp(k,      3'd2, 4'b0100, 1'b1);
      pushExp(k + 8,  3'd2, 4'b0100, 1'b1);
      pushExp(k + 11, 3'd2, 4'b0100, 1'b1);
      pushExp(k + 14, 3'd2, 4'b0100, 1'b1);
      pushExp(k + 17, 3'd2, 4'b0100, 1'b1);
      step(20);
      applyStimulus(1'b0, 1'b0);
      step(3);

      // Pure timeout in SET_AL_HR: back to RUN 20 cycles after entry.
      k = cyc + 1;
      applyStimulus(1'b1, 1'b0);
      pushExp(k,      3'd3, 4'b0000, 1'b1);
      pushExp(k + 20, 3'd0, 4'b0000, 1'b1);
      step(1);
      applyStimulus(1'b0, 1'b0);
      step(22);

      // Timeout restarted by an inc press 15 cycles after entry.
      pressMode(3'd1, 1'b1);
      pressMode(3'd2, 1'b1);
      k = cyc + 1;
      applyStimulus(1'b1, 1'b0);
      pushExp(k,      3'd3, 4'b0000, 1'b1);
      pushExp(k + 15, 3'd3, 4'b0010, 1'b1);
      pushExp(k + 35, 3'd0, 4'b0000, 1'b1);
      step(1);
      applyStimulus(1'b0, 1'b0);
      step(14);
      applyStimulus(1'b0, 1'b1);
      step(1);
      applyStimulus(1'b0, 1'b0);
      step(22);

      // Async reset while an inc_al_min repeat strobe is high.
      pressMode(3'd1, 1'b1);
      pressMode(3'd2, 1'b1);
      pressMode(3'd3, 1'b1);
      pressMode(3'd4, 1'b1);
      k = cyc + 1;
      applyStimulus(1'b0, 1'b1);
      pushExp(k,     3'd4, 4'b0001, 1'b1);
      pushExp(k + 8, 3'd4, 4'b0001, 1'b1);
      step(12);
      checkOutput("strobe_before_reset", curSnap(), mkSnap(3'd4, 4'b0001, 1'b1));
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_drop", curSnap(), 11'h000);
      applyStimulus(1'b0, 1'b0);
      step(2);
      rst_n = 1'b1;
      step(3);
      checkOutput("idle_after_reset", curSnap(), 11'h000);

      // Every queued expectation must have been matched by an output event.
      compared++;
      if (expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL queue_drained: %0d events outstanding, expected 0", expQ.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
